// File: rtl/fdiv_pkg.sv
// Shared definitions for the FP divider issue controller: tag width default,
// exception-flag bit positions and the controller state encoding.
package fdiv_pkg;

    localparam int TAG_W_DEF = 6;
    localparam int FFLAG_W   = 5;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // The divider never reports invalid; inexact follows from over/underflow.
    function automatic logic [FFLAG_W-1:0] make_fflags(input logic dz,
                                                       input logic ovf,
                                                       input logic unf);
        logic [FFLAG_W-1:0] f;
        f        = '0;
        f[FF_NV] = 1'b0;
        f[FF_DZ] = dz;
        f[FF_OF] = ovf;
        f[FF_UF] = unf;
        f[FF_NX] = ovf | unf;
        return f;
    endfunction

endpackage

// File: rtl/fdiv_result_fifo.sv
// Small synchronous result FIFO with first-word-fall-through head, an
// occupancy count and a synchronous clear that wins over push and pop.
module fdiv_result_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             push_eff;
    logic             pop_eff;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign pop_eff  = pop && !empty;
    assign push_eff = push && !full;

    always_ff @(posedge clk) begin
        if (push_eff && !clr) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Issues one FP divide at a time to an external divider and buffers completed
// results; flush kills the in-flight op and drops everything buffered.
module fdiv_issue_ctrl
    import fdiv_pkg::*;
#(
    parameter int TAG_W      = TAG_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               div_start,
    output logic [31:0]        div_a,
    output logic [31:0]        div_b,
    input  logic               div_busy,
    input  logic               div_done,
    input  logic [31:0]        div_result,
    input  logic               div_zero_division,
    input  logic               div_overflow,
    input  logic               div_underflow,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [31:0]        out_result,
    output logic [FFLAG_W-1:0] out_fflags
);

    localparam int ENTRY_W = TAG_W + 32 + FFLAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_t             state_reg;
    state_t             state_next;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               kill_reg;

    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Admission requires a free slot, which stays reserved for the op in flight.
    assign in_ready = rst_n && (state_reg == ST_IDLE)
                      && (fifo_count < CNT_W'(FIFO_DEPTH)) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept)    state_next = ST_ISSUE;
            ST_ISSUE: if (!div_busy) state_next = ST_WAIT;
            ST_WAIT:  if (div_done)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start = 1'b0;
        if (state_reg == ST_ISSUE) begin
            div_start = !div_busy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            tag_reg  <= '0;
            kill_reg <= 1'b0;
        end else if (accept) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            tag_reg  <= in_tag;
            kill_reg <= 1'b0;
        end else if (flush && (state_reg != ST_IDLE)) begin
            kill_reg <= 1'b1;
        end
    end

    assign div_a = a_reg;
    assign div_b = b_reg;

    // A flush in the completion cycle discards the result just like a prior kill.
    assign push      = (state_reg == ST_WAIT) && div_done && !kill_reg && !flush;
    assign push_data = {tag_reg, div_result,
                        make_fflags(div_zero_division, div_overflow, div_underflow)};
    assign pop       = out_valid && out_ready;

    fdiv_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Outputs read as zero whenever nothing is buffered.
    assign out_valid = !fifo_empty;
    assign {out_tag, out_result, out_fflags} = fifo_empty ? '0 : head_data;

endmodule

// File: doc/fdiv_issue_ctrl.md
FDIV_ISSUE_CTRL -- requirements
Module: fdiv_issue_ctrl

Interface
REQ-001 SHALL have parameters: TAG_W, 6, ROB tag width; FIFO_DEPTH, 2, result-buffer entries (power of two, >=2).
REQ-002 SHALL have ports: clk input 1 clock; rst_n input 1 asynchronous active-low reset.
REQ-003 SHALL have ports: flush input 1 pipeline kill; in_valid input 1; in_ready output 1; in_a input 32 dividend; in_b input 32 divisor; in_tag input TAG_W.
REQ-004 SHALL have divider-side ports: div_start output 1; div_a output 32; div_b output 32; div_busy input 1; div_done input 1 (one-cycle pulse); div_result input 32; div_zero_division input 1; div_overflow input 1; div_underflow input 1.
REQ-005 SHALL have result-side ports: out_valid output 1; out_ready input 1; out_tag output TAG_W; out_result output 32; out_fflags output 5 ({NV,DZ,OF,UF,NX}).

Function
REQ-006 SHALL implement FSM IDLE, ISSUE, WAIT; one divide in flight at most.
REQ-007 SHALL drive in_ready = (state==IDLE) && (fifo_count < FIFO_DEPTH) && !flush, combinationally.
REQ-008 SHALL, on in_valid && in_ready, latch in_a/in_b/in_tag into operand registers, clear kill flag, go IDLE->ISSUE.
REQ-009 SHALL, in ISSUE, assert div_start for exactly one cycle when div_busy==0, then go WAIT; if div_busy==1, hold ISSUE with div_start low.
REQ-010 SHALL drive div_a/div_b from operand registers, stable from ISSUE until WAIT exits.
REQ-011 SHALL, in WAIT, on div_done: if kill flag clear, push {tag, div_result, fflags} into result FIFO; go IDLE regardless.
REQ-012 SHALL form fflags as NV=0, DZ=div_zero_division, OF=div_overflow, UF=div_underflow, NX=div_overflow|div_underflow, sampled in the div_done cycle.
REQ-013 SHALL never overflow the FIFO; admission in REQ-007 reserves the slot for the in-flight op.
REQ-014 SHALL present FIFO head on out_*; out_valid = FIFO non-empty; pop on out_valid && out_ready; push and pop in the same cycle both take effect.
REQ-015 SHALL give latency: accept at cycle T -> div_start at T+1 (div_busy low) -> push in div_done cycle D -> out_valid at D+1 when FIFO was empty.
REQ-016 SHALL accept the next op no earlier than the cycle after div_done.
REQ-017 SHALL, on flush: empty FIFO next cycle (out_valid low); if in ISSUE or WAIT set kill flag, still complete the divider handshake, discard the result.
REQ-018 SHALL, when flush and div_done coincide, discard that result and return to IDLE.
REQ-019 SHALL keep out_tag/out_result/out_fflags stable while out_valid && !out_ready.

Reset
REQ-020 SHALL on rst_n low asynchronously set: state IDLE, kill flag 0, FIFO empty (pointers/count 0), div_start 0, div_a/div_b 0, out_valid 0, out_tag/out_result/out_fflags 0, in_ready 0 while asserted.
REQ-021 SHALL, after reset mid-operation, ignore any div_done arriving in IDLE (no push).

Structure
REQ-022 SHALL place TAG_W default, FFLAG bit indices (NV=4, DZ=3, OF=2, UF=1, NX=0) and state enum in shared package fdiv_pkg.
REQ-023 SHALL implement result buffer as sub-module fdiv_result_fifo (synchronous FIFO, width TAG_W+37, depth FIFO_DEPTH, count output).

Verification
REQ-024 SHALL cover: a=0x40C00000, b=0x40000000, tag=5, out_ready=1 -> one div_start pulse; out_valid with tag 5, result 0x40400000, fflags 0x00.
REQ-025 SHALL cover: a=0x3F800000, b=0x00000000, tag=9 -> result 0x7F800000, fflags 0x08 (DZ only), out_valid one cycle after div_done.
REQ-026 SHALL cover: out_ready=0, ops tags 1,2 -> both buffered, in_ready low with third pending; raise out_ready -> tags 1,2 in order, then third accepted.
REQ-027 SHALL cover: flush pulse in WAIT for tag 3 -> no out_valid for tag 3; next op tag 4 (6.0/2.0) completes normally with 0x40400000.
REQ-028 SHALL cover: flush coincident with div_done, and rst_n low mid-WAIT followed by stray div_done -> no push; all outputs at reset values.
REQ-029 SHALL cover: div_busy held high 3 cycles after accept -> div_start held low, asserted once in first cycle div_busy low.
